button_poller: RTL and testbench
================================

# button_poller

Avalon-MM initiator that periodically reads the 4-bit buttons input PIO (slave register at word address 0, registered readdata, one-cycle read latency) and turns the raw active-low samples into debounced, active-high button state plus one-cycle press/release pulses. It sits between the buttons PIO slave port and the fabric logic or interrupt logic that consumes button events. The block never writes; it only issues single reads to address 0.

## Interface
- POLL_DIV, 50000: clock cycles between poll reads; legal range 4..2^20.
- DEBOUNCE_N, 4: consecutive equal polls needed to accept a new level; legal range 1..15.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m_address  out  2  read address; constant 2'd0.
- m_read  out  1  read strobe, one cycle per poll.
- m_readdata  in  32  slave readdata; only bits [3:0] are used.
- btn_state  out  4  debounced state, 1 = pressed.
- btn_press  out  4  one-cycle pulse per bit on a debounced 0->1 transition of `btn_state`.
- btn_release  out  4  one-cycle pulse per bit on a debounced 1->0 transition of `btn_state`.
- irq  out  1  interrupt output; present only with the macro defined.
- irq_ack  in  1  clears the event latch; present only with the macro defined.

## Operation
- Divider: free-running counter 0..POLL_DIV-1; `tick` = count == POLL_DIV-1.
- FSM states: IDLE, READ, CAPTURE, UPDATE.
  - IDLE -> READ on `tick`.
  - READ: `m_read`=1 for exactly this cycle -> CAPTURE.
  - CAPTURE: register `raw = ~m_readdata[3:0]` -> UPDATE.
  - UPDATE: run the debounce step -> IDLE.
- POLL_DIV>=4 guarantees `tick` only occurs in IDLE. A `tick` in any other state is ignored.
- Debounce, per bit i, with a 4-bit counter `cnt[i]`:
  - raw[i]==btn_state[i]: cnt[i] <- 0.
  - Otherwise cnt[i] <- cnt[i]+1.
  - When cnt[i]+1 == DEBOUNCE_N: btn_state[i] flips, cnt[i] <- 0, and `btn_press[i]` or `btn_release[i]` pulses.
- Bits are independent. Several bits may change, and pulse, in the same UPDATE cycle.
- A glitch shorter than DEBOUNCE_N consecutive polls never changes `btn_state`.
- Reset (asynchronous, any state, including mid-read) sets:
  - FSM = IDLE, divider = 0, `cnt` = 0.
  - `btn_state`, `btn_press`, `btn_release` = 0.
  - `m_read` = 0, `m_address` = 0, `irq` = 0.
  - After reset the buttons are treated as released. A button held through reset produces `btn_press` after DEBOUNCE_N polls.

## Timing
- Cycle T: `tick` in IDLE.
- T+1: READ; `m_read`=1.
- T+2: CAPTURE; samples the slave data registered at the end of T+1.
- T+3: UPDATE.
- T+4: `btn_state`, `btn_press` and `btn_release` show the new values.
- Pulses are exactly one cycle wide.
- Polls are exactly POLL_DIV cycles apart.
- Worst-case acceptance latency of a clean level change is DEBOUNCE_N*POLL_DIV+4 cycles.
- `m_read` is never asserted in two consecutive cycles. The block ignores waitrequest; the slave has none.

## Configuration
- Macro: `BUTTON_POLLER_IRQ_EN`.
- Defined:
  - A 4-bit sticky `evt` register ORs in `btn_press` every cycle; `irq` = |evt.
  - `irq_ack`=1 clears `evt` on the next clock edge.
  - If a press pulse coincides with `irq_ack`, the pulse wins: that bit stays set.
- Not defined: `irq`, `irq_ack` and `evt` do not exist. Debounce behaviour is identical.

## Test plan
All scenarios use POLL_DIV=4 and DEBOUNCE_N=3.
- Reset release with the slave returning 0xF (all released) -> `m_read` pulses every 4 cycles with `m_address`=0; `btn_state` stays 0; no pulses.
- Slave switches to 0xE (button 0 held) -> `btn_press` = 4'b0001 for one cycle 4 cycles after the 3rd poll sees 0xE; `btn_state` = 4'b0001.
- Slave returns 0xE for 2 polls, then 0xF -> `btn_state` stays 0; `btn_press` is never asserted.
- From `btn_state`=4'b0011, the slave returns 0xC->0xF for 3 polls -> a single `btn_release`=4'b0011 pulse; `btn_state`=0.
- Assert reset_n=0 during READ, then release with the slave returning 0x0 -> all outputs 0 immediately; `btn_press`=4'hF after the 3rd poll.
- With `BUTTON_POLLER_IRQ_EN`:
  - A press on bit 2 -> `irq`=1 and stays 1.
  - `irq_ack` for one cycle -> `irq`=0 on the next cycle.
  - `irq_ack` in the same cycle as a new `btn_press` -> `irq` stays 1.

Source files
------------

// File: rtl/button_poller.sv
// Avalon-MM read initiator that polls the buttons PIO, debounces the active-low samples and emits press/release pulses.
// Optional interrupt logic (irq, irq_ack, sticky event latch) is enabled by defining BUTTON_POLLER_IRQ_EN.
module button_poller #(
    parameter int POLL_DIV   = 50000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
`ifdef BUTTON_POLLER_IRQ_EN
    output logic        irq,
    input  logic        irq_ack,
`endif
    output logic [3:0]  btn_state,
    output logic [3:0]  btn_press,
    output logic [3:0]  btn_release
);

    // state   | meaning
    // IDLE    | wait for the divider tick
    // READ    | m_read strobe to the PIO data register
    // CAPTURE | latch inverted readdata into raw
    // UPDATE  | per-bit debounce step, outputs visible next cycle
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       raw;
    logic [3:0]       cnt [4];
    logic [27:0]      unused_readdata;

    assign unused_readdata = m_readdata[31:4];
    assign m_address       = 2'd0;
    assign tick            = (div_cnt == DIV_W'(POLL_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_read    = 1'b0;
        case (state)
            IDLE:    if (tick) state_nxt = READ;
            READ: begin
                m_read    = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw <= '0;
        end else if (state == CAPTURE) begin
            raw <= ~m_readdata[3:0];
        end
    end

    // A counter only advances while raw disagrees with the accepted level, so any agreeing poll restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            if (state == UPDATE) begin
                for (int i = 0; i < 4; i++) begin
                    if (raw[i] == btn_state[i]) begin
                        cnt[i] <= '0;
                    end else if (({1'b0, cnt[i]} + 5'd1) == 5'(DEBOUNCE_N)) begin
                        btn_state[i]   <= raw[i];
                        btn_press[i]   <= raw[i];
                        btn_release[i] <= ~raw[i];
                        cnt[i]         <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef BUTTON_POLLER_IRQ_EN
    logic [3:0] evt;

    // A press arriving alongside irq_ack survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt <= '0;
        end else begin
            evt <= (irq_ack ? 4'd0 : evt) | btn_press;
        end
    end

    assign irq = |evt;
`endif

endmodule

// File: tb/tb_button_poller.sv
// Directed bench for button_poller with POLL_DIV=4, DEBOUNCE_N=3 and a registered one-cycle-latency PIO model.
// Interrupt checks run only when BUTTON_POLLER_IRQ_EN is defined.
module tb_button_poller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic [3:0]  btn_state, btn_press, btn_release;
    logic [3:0]  slave_val;
`ifdef BUTTON_POLLER_IRQ_EN
    logic        irq;
    logic        irq_ack;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    button_poller #(.POLL_DIV(4), .DEBOUNCE_N(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_address   (m_address),
        .m_read      (m_read),
        .m_readdata  (m_readdata),
`ifdef BUTTON_POLLER_IRQ_EN
        .irq         (irq),
        .irq_ack     (irq_ack),
`endif
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always_ff @(posedge clk) begin
        if (m_read) m_readdata <= {28'd0, slave_val};
    end

    typedef struct {
        logic [3:0] val;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_read();
        int n = 0;
        while (m_read !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("read_timeout", {3'd0, m_read}, 4'd1);
    endtask

    // Enter with slave_val set, at a negedge no later than the READ cycle; leave at the negedge of the next READ.
    task automatic do_poll(input logic [3:0] val, input logic [3:0] st,
                           input logic [3:0] pr, input logic [3:0] rl, input string tag);
        slave_val = val;
        wait_read();
        check({tag, "_addr"}, {2'd0, m_address}, 4'd0);
        @(negedge clk);
        check({tag, "_read_gap"}, {3'd0, m_read}, 4'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_state"}, btn_state, st);
        check({tag, "_press"}, btn_press, pr);
        check({tag, "_release"}, btn_release, rl);
        @(negedge clk);
        check({tag, "_press_width"}, btn_press, 4'd0);
        check({tag, "_release_width"}, btn_release, 4'd0);
        check({tag, "_period"}, {3'd0, m_read}, 4'd1);
    endtask

    initial begin
        vecs[0]  = '{4'hF, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'hF, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{4'hE, 4'h0, 4'h0, 4'h0};
        vecs[3]  = '{4'hE, 4'h0, 4'h0, 4'h0};
        vecs[4]  = '{4'hF, 4'h0, 4'h0, 4'h0};
        vecs[5]  = '{4'hE, 4'h0, 4'h0, 4'h0};
        vecs[6]  = '{4'hE, 4'h0, 4'h0, 4'h0};
        vecs[7]  = '{4'hE, 4'h1, 4'h1, 4'h0};
        vecs[8]  = '{4'hE, 4'h1, 4'h0, 4'h0};
        vecs[9]  = '{4'hC, 4'h1, 4'h0, 4'h0};
        vecs[10] = '{4'hC, 4'h1, 4'h0, 4'h0};
        vecs[11] = '{4'hC, 4'h3, 4'h2, 4'h0};
        vecs[12] = '{4'hF, 4'h3, 4'h0, 4'h0};
        vecs[13] = '{4'hF, 4'h3, 4'h0, 4'h0};
        vecs[14] = '{4'hF, 4'h0, 4'h0, 4'h3};
        vecs[15] = '{4'hF, 4'h0, 4'h0, 4'h0};
        vecs[16] = '{4'h7, 4'h0, 4'h0, 4'h0};
        vecs[17] = '{4'h3, 4'h0, 4'h0, 4'h0};
        vecs[18] = '{4'h3, 4'h8, 4'h8, 4'h0};
        vecs[19] = '{4'h3, 4'hC, 4'h4, 4'h0};
        vecs[20] = '{4'hF, 4'hC, 4'h0, 4'h0};
        vecs[21] = '{4'hF, 4'hC, 4'h0, 4'h0};
        vecs[22] = '{4'hF, 4'h0, 4'h0, 4'hC};

        slave_val  = 4'hF;
        m_readdata = 32'd0;
`ifdef BUTTON_POLLER_IRQ_EN
        irq_ack = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", btn_state, 4'h0);
        check("rst_press", btn_press, 4'h0);
        check("rst_release", btn_release, 4'h0);
        check("rst_read", {3'd0, m_read}, 4'd0);
`ifdef BUTTON_POLLER_IRQ_EN
        check("rst_irq", {3'd0, irq}, 4'd0);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            do_poll(vecs[i].val, vecs[i].st, vecs[i].pr, vecs[i].rl, $sformatf("v%0d", i));
        end

        // Hold all four, then reset in the middle of a READ cycle.
        do_poll(4'h0, 4'h0, 4'h0, 4'h0, "hold1");
        do_poll(4'h0, 4'h0, 4'h0, 4'h0, "hold2");
        do_poll(4'h0, 4'hF, 4'hF, 4'h0, "hold3");
        check("pre_rst_read", {3'd0, m_read}, 4'd1);
        reset_n = 1'b0;
        #1;
        check("midrd_state", btn_state, 4'h0);
        check("midrd_read", {3'd0, m_read}, 4'd0);
        check("midrd_press", btn_press, 4'h0);
        check("midrd_addr", {2'd0, m_address}, 4'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_poll(4'h0, 4'h0, 4'h0, 4'h0, "post1");
        do_poll(4'h0, 4'h0, 4'h0, 4'h0, "post2");
        do_poll(4'h0, 4'hF, 4'hF, 4'h0, "post3");

`ifdef BUTTON_POLLER_IRQ_EN
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        do_poll(4'hB, 4'h0, 4'h0, 4'h0, "irqp1");
        do_poll(4'hB, 4'h0, 4'h0, 4'h0, "irqp2");
        check("irq_before", {3'd0, irq}, 4'd0);
        do_poll(4'hB, 4'h4, 4'h4, 4'h0, "irqp3");
        check("irq_set", {3'd0, irq}, 4'd1);
        repeat (5) @(negedge clk);
        check("irq_sticky", {3'd0, irq}, 4'd1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("irq_cleared", {3'd0, irq}, 4'd0);
        do_poll(4'hA, 4'h4, 4'h0, 4'h0, "coin1");
        do_poll(4'hA, 4'h4, 4'h0, 4'h0, "coin2");
        slave_val = 4'hA;
        wait_read();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("coin_press", btn_press, 4'h1);
        check("coin_irq_low", {3'd0, irq}, 4'd0);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("coin_irq_kept", {3'd0, irq}, 4'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
